// File: rtl/filter_pkg.sv
// filter_pkg: shared pixel/line defaults for the 3x3 filter front end.
// Rev 1.0 - initial release.
`default_nettype none

package filter_pkg;

  localparam int DEF_DATA_W    = 10;
  localparam int DEF_IMG_WIDTH = 640;
  localparam int DEF_COL_W     = $clog2(DEF_IMG_WIDTH);

  // Row count only needs to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] row_inc(input logic [1:0] row);
    return (row == 2'd2) ? 2'd2 : row + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// line_buffer: single-clock DEPTH x DATA_W RAM, registered read-before-write, clock enable.
// Rev 1.0 - initial release.
`default_nettype none

module line_buffer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_ce,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Contents are deliberately not reset; consumers mask stale data by row.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_rd_en) r_q <= r_mem[i_rd_addr];
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_q;

endmodule

`default_nettype wire

// File: rtl/line_window_3x3.sv
// line_window_3x3: raster stream to 3x3 neighbourhood taps, two-stage pipeline.
// Rev 1.0 - initial release. Optional LINE_WINDOW_ZERO_PAD_EN: zero-padded borders, every pixel windowed.
`default_nettype none

module line_window_3x3
  import filter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              clken,
  input  logic              sof,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] row1_1,
  output logic [DATA_W-1:0] row1_2,
  output logic [DATA_W-1:0] row1_3,
  output logic [DATA_W-1:0] row2_1,
  output logic [DATA_W-1:0] row2_2,
  output logic [DATA_W-1:0] row2_3,
  output logic [DATA_W-1:0] row3_1,
  output logic [DATA_W-1:0] row3_2,
  output logic [DATA_W-1:0] row3_3,
  output logic              win_valid,
  output logic              win_last
);

  localparam int              COL_W      = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);

  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_row;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_din;
  logic [COL_W-1:0]  r_s1_col;
  logic [1:0]        r_s1_row;
  logic [DATA_W-1:0] r_tap [3][3];
  logic              r_win_valid;
  logic              r_win_last;

  logic [COL_W-1:0]  w_col;
  logic [1:0]        w_row;
  logic              w_wrap;
  logic [DATA_W-1:0] w_a_q;
  logic [DATA_W-1:0] w_b_q;
  logic [DATA_W-1:0] w_new_b;
  logic [DATA_W-1:0] w_new_a;
  logic              w_keep;
  logic              w_win_ok;

  // Position of the pixel presented this cycle; sof overrides the counters.
  assign w_col  = sof ? '0 : r_col;
  assign w_row  = sof ? '0 : r_row;
  assign w_wrap = (w_col == C_COL_LAST);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_din   <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
    end else if (clken) begin
      r_s1_valid <= din_valid;
      if (din_valid) begin
        r_col    <= w_wrap ? '0 : w_col + 1'b1;
        r_row    <= w_wrap ? row_inc(w_row) : w_row;
        r_s1_din <= din;
        r_s1_col <= w_col;
        r_s1_row <= w_row;
      end
    end
  end

  // A holds line y-1 and is refreshed with din; B takes A's displaced word one cycle later.
  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH)
  ) u_buf_a (
    .clk       (clk),
    .i_ce      (clken),
    .i_rd_en   (din_valid),
    .i_rd_addr (w_col),
    .i_wr_en   (din_valid),
    .i_wr_addr (w_col),
    .i_wr_data (din),
    .o_rd_data (w_a_q)
  );

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH)
  ) u_buf_b (
    .clk       (clk),
    .i_ce      (clken),
    .i_rd_en   (din_valid),
    .i_rd_addr (w_col),
    .i_wr_en   (r_s1_valid),
    .i_wr_addr (r_s1_col),
    .i_wr_data (w_a_q),
    .o_rd_data (w_b_q)
  );

`ifdef LINE_WINDOW_ZERO_PAD_EN
  // Lines above the frame read as zero; columns left of x=0 are cleared on the line's first pixel.
  assign w_new_b  = (r_s1_row == 2'd2) ? w_b_q : '0;
  assign w_new_a  = (r_s1_row != 2'd0) ? w_a_q : '0;
  assign w_keep   = (r_s1_col != '0);
  assign w_win_ok = 1'b1;
`else
  assign w_new_b  = w_b_q;
  assign w_new_a  = w_a_q;
  assign w_keep   = 1'b1;
  assign w_win_ok = (r_s1_col >= C_COL_TWO) && (r_s1_row == 2'd2);
`endif

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_tap[i][j] <= '0;
        end
      end
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (clken) begin
      r_win_valid <= r_s1_valid && w_win_ok;
      r_win_last  <= r_s1_valid && w_win_ok && (r_s1_col == C_COL_LAST);
      if (r_s1_valid) begin
        for (int i = 0; i < 3; i++) begin
          r_tap[i][0] <= w_keep ? r_tap[i][1] : '0;
          r_tap[i][1] <= w_keep ? r_tap[i][2] : '0;
        end
        r_tap[0][2] <= w_new_b;
        r_tap[1][2] <= w_new_a;
        r_tap[2][2] <= r_s1_din;
      end
    end
  end

  assign row1_1    = r_tap[0][0];
  assign row1_2    = r_tap[0][1];
  assign row1_3    = r_tap[0][2];
  assign row2_1    = r_tap[1][0];
  assign row2_2    = r_tap[1][1];
  assign row2_3    = r_tap[1][2];
  assign row3_1    = r_tap[2][0];
  assign row3_2    = r_tap[2][1];
  assign row3_3    = r_tap[2][2];
  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;

endmodule

`default_nettype wire
